// File: rtl/rw_fifo_ext.sv
// Parametrised synchronous FIFO with empty-FIFO bypass, occupancy count, programmable
// almost-full threshold, combinational head peek and sticky overflow/underflow flags.
module rw_fifo_ext #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 4,
  parameter int AFULL_LVL   = DEPTH - 1,
  parameter int DEF_TO_ZERO = 1,
  parameter int BYPASS      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         read_next,
  input  logic                         clr_err,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  output logic [DATA_WIDTH-1:0]        peek_out,
  output logic                         has_peek,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         almost_full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam bit BYP_EN = (BYPASS != 0);
  localparam bit DZ_EN  = (DEF_TO_ZERO != 0);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]         head_reg, head_next;
  logic [PW-1:0]         tail_reg, tail_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [DATA_WIDTH-1:0] dout_reg, dout_next;
  logic                  dv_reg, dv_next;
  logic                  ovf_reg, ovf_next;
  logic                  udf_reg, udf_next;

  logic full_w, empty_w;
  logic do_write, do_read, bypass, store, pop;

  assign full_w  = (count_reg == CW'(DEPTH));
  assign empty_w = (count_reg == '0);

  always_comb begin
    do_write = wen & (~full_w | read_next);
    do_read  = read_next & (~empty_w | (BYP_EN & wen));
    bypass   = BYP_EN & empty_w & wen & read_next;
    // A bypassed word never touches storage, pointers or count.
    store    = do_write & ~bypass;
    pop      = do_read & ~bypass;

    head_next = head_reg;
    if (pop) begin
      head_next = (head_reg == PW'(DEPTH - 1)) ? '0 : head_reg + 1'b1;
    end

    tail_next = tail_reg;
    if (store) begin
      tail_next = (tail_reg == PW'(DEPTH - 1)) ? '0 : tail_reg + 1'b1;
    end

    count_next = count_reg;
    case ({store, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    dv_next = do_read;
    if (bypass) begin
      dout_next = data_in;
    end else if (pop) begin
      dout_next = mem_reg[head_reg];
    end else if (DZ_EN) begin
      dout_next = '0;
    end else begin
      dout_next = dout_reg;
    end

    // Set events take priority over a same-cycle clear.
    ovf_next = (wen & ~do_write) | (ovf_reg & ~clr_err);
    udf_next = (read_next & ~do_read) | (udf_reg & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      dout_reg  <= '0;
      dv_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      dout_reg  <= dout_next;
      dv_reg    <= dv_next;
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && store) begin
      mem_reg[tail_reg] <= data_in;
    end
  end

  assign data_out    = dout_reg;
  assign data_valid  = dv_reg;
  assign peek_out    = empty_w ? '0 : mem_reg[head_reg];
  assign has_peek    = ~empty_w;
  assign count       = count_reg;
  assign full        = full_w;
  assign almost_full = (count_reg >= CW'(AFULL_LVL));
  assign empty       = empty_w;
  assign overflow    = ovf_reg;
  assign underflow   = udf_reg;

endmodule
